// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: ALU operations, forwarding
// selects, result-source selects and branch conditions.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SLT  = 3'b101,
    ALU_SLTU = 3'b110,
    ALU_SLL  = 3'b111
  } alu_op_e;

  // Forwarding selects from the hazard unit; 2'b11 falls back to the register value.
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU for the execute stage.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ALUResult
);

  alu_op_e op;
  assign op = alu_op_e'(ALUControl);

  // Select the operation result; add and sub simply wrap at XLEN bits.
  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    ALUResult = '0;
    case (op)
      ALU_ADD:  ALUResult = SrcA + SrcB;
      ALU_SUB:  ALUResult = SrcA - SrcB;
      ALU_AND:  ALUResult = SrcA & SrcB;
      ALU_OR:   ALUResult = SrcA | SrcB;
      ALU_XOR:  ALUResult = SrcA ^ SrcB;
      ALU_SLT:  ALUResult = {{(XLEN-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      ALU_SLTU: ALUResult = {{(XLEN-1){1'b0}}, (SrcA < SrcB)};
      ALU_SLL:  ALUResult = SrcA << SrcB[4:0];
      default:  ALUResult = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I core: ID/EX register with flush,
// operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module execute_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushE,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            JumpD,
  input  logic            JalrD,
  input  logic            BranchD,
  input  logic            ALUSrcD,
  input  logic [1:0]      ResultSrcD,
  input  logic [2:0]      ALUControlD,
  input  logic [2:0]      Funct3D,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic [XLEN-1:0] ResultW,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic            ResultSrcE0,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM
);

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            jalr;
    logic            branch;
    logic            alu_src;
    logic [1:0]      result_src;
    logic [2:0]      alu_control;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic [1:0]      result_src;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
  } ex_mem_t;

  id_ex_t          d_bundle;
  id_ex_t          e;
  ex_mem_t         m;
  logic [XLEN-1:0] src_a_e;
  logic [XLEN-1:0] write_data_e;
  logic [XLEN-1:0] src_b_e;
  logic [XLEN-1:0] alu_result_e;
  logic [XLEN-1:0] jalr_sum;
  logic            taken;

  assign d_bundle = '{
    reg_write:   RegWriteD,
    mem_write:   MemWriteD,
    jump:        JumpD,
    jalr:        JalrD,
    branch:      BranchD,
    alu_src:     ALUSrcD,
    result_src:  ResultSrcD,
    alu_control: ALUControlD,
    funct3:      Funct3D,
    rs1:         Rs1D,
    rs2:         Rs2D,
    rd:          RdD,
    rd1:         RD1D,
    rd2:         RD2D,
    pc:          PCD,
    pc_plus4:    PCPlus4D,
    imm:         ImmExtD
  };

  // ID/EX register: a flush loads an all-zero bubble and wins over new data.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (reset)       e <= '0;
    else if (FlushE) e <= '0;
    else             e <= d_bundle;
  end

  // Forwarding muxes; the spare select 2'b11 returns the register value.
  always_comb begin
    src_a_e      = e.rd1;
    write_data_e = e.rd2;
    case (ForwardAE)
      FWD_WB:  src_a_e = ResultW;
      FWD_MEM: src_a_e = m.alu_result;
      default: src_a_e = e.rd1;
    endcase
    case (ForwardBE)
      FWD_WB:  write_data_e = ResultW;
      FWD_MEM: write_data_e = m.alu_result;
      default: write_data_e = e.rd2;
    endcase
  end

  assign src_b_e = e.alu_src ? e.imm : write_data_e;

  alu #(.XLEN(XLEN)) u_alu (
    .SrcA       (src_a_e),
    .SrcB       (src_b_e),
    .ALUControl (e.alu_control),
    .ALUResult  (alu_result_e)
  );

  // Branch condition evaluated on the forwarded register operands.
  always_comb begin
    taken = 1'b0;
    case (e.funct3)
      F3_BEQ:  taken = (src_a_e == write_data_e);
      F3_BNE:  taken = (src_a_e != write_data_e);
      F3_BLT:  taken = ($signed(src_a_e) <  $signed(write_data_e));
      F3_BGE:  taken = ($signed(src_a_e) >= $signed(write_data_e));
      F3_BLTU: taken = (src_a_e <  write_data_e);
      F3_BGEU: taken = (src_a_e >= write_data_e);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum  = src_a_e + e.imm;
  assign PCSrcE    = e.jump | (e.branch & taken);
  assign PCTargetE = e.jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (e.pc + e.imm);

  // EX/MEM register: loads every edge, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '0;
    end else begin
      m.reg_write  <= e.reg_write;
      m.mem_write  <= e.mem_write;
      m.result_src <= e.result_src;
      m.rd         <= e.rd;
      m.alu_result <= alu_result_e;
      m.write_data <= write_data_e;
      m.pc_plus4   <= e.pc_plus4;
    end
  end

  assign Rs1E        = e.rs1;
  assign Rs2E        = e.rs2;
  assign RdE         = e.rd;
  assign ResultSrcE0 = e.result_src[0];
  assign ALUResultM  = m.alu_result;
  assign WriteDataM  = m.write_data;
  assign PCPlus4M    = m.pc_plus4;
  assign RdM         = m.rd;
  assign RegWriteM   = m.reg_write;
  assign MemWriteM   = m.mem_write;
  assign ResultSrcM  = m.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: a vector table for ALU/branch/jump
// behaviour plus hand-written reset, forwarding and flush sequences.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        FlushE;
  logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        RegWriteD, MemWriteD, JumpD, JalrD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD, Funct3D;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ResultSrcE0, PCSrcE;
  logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .FlushE(FlushE),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD), .JalrD(JalrD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .ALUControlD(ALUControlD), .Funct3D(Funct3D),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ResultSrcE0(ResultSrcE0),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM)
  );

  typedef struct {
    string       name;
    logic [2:0]  alu;
    logic        alu_src;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        exp_pcsrc;
    logic [31:0] exp_target;
    logic [31:0] exp_alu;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    FlushE = 0; RD1D = 0; RD2D = 0; PCD = 0; PCPlus4D = 0; ImmExtD = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; RegWriteD = 0; MemWriteD = 0; JumpD = 0;
    JalrD = 0; BranchD = 0; ALUSrcD = 0; ResultSrcD = 0; ALUControlD = 0;
    Funct3D = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " RdE"},        {27'd0, RdE},       32'd0);
    check({tag, " Rs1E"},       {27'd0, Rs1E},      32'd0);
    check({tag, " PCSrcE"},     {31'd0, PCSrcE},    32'd0);
    check({tag, " PCTargetE"},  PCTargetE,          32'd0);
    check({tag, " ALUResultM"}, ALUResultM,         32'd0);
    check({tag, " RdM"},        {27'd0, RdM},       32'd0);
    check({tag, " RegWriteM"},  {31'd0, RegWriteM}, 32'd0);
    check({tag, " MemWriteM"},  {31'd0, MemWriteM}, 32'd0);
  endtask

  initial begin
    // name, alu, alu_src, branch, jump, jalr, f3, a, b, pc, imm, pcsrc, target, alu result
    vecs[0]  = '{"add_wrap", 3'b000, 0, 0, 0, 0, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h0, 0, 32'h200, 32'h0};
    vecs[1]  = '{"slt_neg",  3'b101, 0, 0, 0, 0, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h1};
    vecs[2]  = '{"sltu",     3'b110, 0, 0, 0, 0, 3'b000, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 0, 32'h0, 32'h0};
    vecs[3]  = '{"sll_23",   3'b111, 0, 0, 0, 0, 3'b000, 32'h1, 32'h23, 32'h0, 32'h0, 0, 32'h0, 32'h8};
    vecs[4]  = '{"sub_neg",  3'b001, 0, 0, 0, 0, 3'b000, 32'h5, 32'h7, 32'h0, 32'h0, 0, 32'h0, 32'hFFFF_FFFE};
    vecs[5]  = '{"and",      3'b010, 0, 0, 0, 0, 3'b000, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 0, 32'h0, 32'hF000};
    vecs[6]  = '{"or",       3'b011, 0, 0, 0, 0, 3'b000, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 0, 32'h0, 32'hFFF0};
    vecs[7]  = '{"xor",      3'b100, 0, 0, 0, 0, 3'b000, 32'hF0F0, 32'hFF00, 32'h0, 32'h0, 0, 32'h0, 32'h0FF0};
    vecs[8]  = '{"bne_eq",   3'b001, 0, 1, 0, 0, 3'b001, 32'h5, 32'h5, 32'h100, 32'h40, 0, 32'h140, 32'h0};
    vecs[9]  = '{"blt",      3'b001, 0, 1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1, 32'h140, 32'hFFFF_FFFE};
    vecs[10] = '{"bltu",     3'b001, 0, 1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0, 32'h140, 32'hFFFF_FFFE};
    vecs[11] = '{"beq",      3'b001, 0, 1, 0, 0, 3'b000, 32'h5, 32'h5, 32'h100, 32'h40, 1, 32'h140, 32'h0};
    vecs[12] = '{"bge",      3'b001, 0, 1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 0, 32'h140, 32'hFFFF_FFFE};
    vecs[13] = '{"bgeu",     3'b001, 0, 1, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h40, 1, 32'h140, 32'hFFFF_FFFE};
    vecs[14] = '{"f3_011",   3'b001, 0, 1, 0, 0, 3'b011, 32'h1, 32'h2, 32'h100, 32'h40, 0, 32'h140, 32'hFFFF_FFFF};
    vecs[15] = '{"jalr",     3'b000, 1, 0, 1, 1, 3'b000, 32'h1003, 32'h9, 32'h300, 32'h4, 1, 32'h1006, 32'h1007};

    clear_inputs();

    // Reset held across edges with a live instruction at D.
    reset = 1; RegWriteD = 1; RdD = 5;
    tick(); tick();
    check_all_zero("reset_hold");

    // Deassert mid-cycle; two edges bring the instruction to M.
    @(negedge clk); #2 reset = 0;
    tick();
    check("post_reset RdE", {27'd0, RdE}, 32'd5);
    tick();
    check("post_reset RdM", {27'd0, RdM}, 32'd5);
    check("post_reset RegWriteM", {31'd0, RegWriteM}, 32'd1);

    // Asynchronous reset between edges clears both stages at once.
    #2 reset = 1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk); reset = 0;
    clear_inputs();

    // Table of single instructions: E-stage outputs after one edge, M after two.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      clear_inputs();
      ALUControlD = vecs[i].alu; ALUSrcD = vecs[i].alu_src; BranchD = vecs[i].branch;
      JumpD = vecs[i].jump; JalrD = vecs[i].jalr; Funct3D = vecs[i].f3;
      RD1D = vecs[i].a; RD2D = vecs[i].b; PCD = vecs[i].pc; ImmExtD = vecs[i].imm;
      PCPlus4D = vecs[i].pc + 32'd4; RegWriteD = 1; RdD = 5'(i + 1);
      tick();
      check({vecs[i].name, " PCSrcE"}, {31'd0, PCSrcE}, {31'd0, vecs[i].exp_pcsrc});
      check({vecs[i].name, " PCTargetE"}, PCTargetE, vecs[i].exp_target);
      tick();
      check({vecs[i].name, " ALUResultM"}, ALUResultM, vecs[i].exp_alu);
      check({vecs[i].name, " WriteDataM"}, WriteDataM, vecs[i].b);
      check({vecs[i].name, " PCPlus4M"}, PCPlus4M, vecs[i].pc + 32'd4);
      check({vecs[i].name, " RdM"}, {27'd0, RdM}, 32'(i + 1));
    end

    // Forwarding: producer 0x10 in M, consumer 1+2 in E with A<-M and B<-W.
    @(negedge clk);
    clear_inputs();
    ALUControlD = 3'b000; RD1D = 32'h10; RD2D = 32'h0; RegWriteD = 1; RdD = 5'd3;
    tick();
    @(negedge clk);
    RD1D = 32'h1; RD2D = 32'h2; RdD = 5'd4;
    tick();
    check("fwd producer ALUResultM", ALUResultM, 32'h10);
    ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'h20;
    tick();
    check("fwd mem_wb ALUResultM", ALUResultM, 32'h30);
    check("fwd mem_wb WriteDataM", WriteDataM, 32'h20);
    @(negedge clk);
    ForwardAE = 2'b11; ForwardBE = 2'b11;
    tick();
    check("fwd sel11 ALUResultM", ALUResultM, 32'h3);
    check("fwd sel11 WriteDataM", WriteDataM, 32'h2);

    // Branch compare uses forwarded operands: W value 7 vs register 7 -> beq taken.
    @(negedge clk);
    clear_inputs();
    BranchD = 1; Funct3D = 3'b000; RD1D = 32'h1; RD2D = 32'h7; PCD = 32'h80; ImmExtD = 32'h10;
    tick();
    ForwardAE = 2'b01; ResultW = 32'h7;
    #1;
    check("fwd beq PCSrcE", {31'd0, PCSrcE}, 32'd1);
    check("fwd beq PCTargetE", PCTargetE, 32'h90);

    // Same instruction without flush reaches M with its controls set.
    @(negedge clk);
    clear_inputs();
    MemWriteD = 1; JumpD = 1; RegWriteD = 1; RdD = 5'd9; ResultSrcD = 2'b01;
    tick();
    check("noflush PCSrcE", {31'd0, PCSrcE}, 32'd1);
    check("noflush ResultSrcE0", {31'd0, ResultSrcE0}, 32'd1);
    @(negedge clk);
    clear_inputs();
    tick();
    check("noflush MemWriteM", {31'd0, MemWriteM}, 32'd1);
    check("noflush ResultSrcM", {30'd0, ResultSrcM}, 32'd1);

    // Flush: the bubble asserts nothing in E and delivers no writes to M.
    @(negedge clk);
    clear_inputs();
    FlushE = 1; MemWriteD = 1; JumpD = 1; RegWriteD = 1; RdD = 5'd9;
    tick();
    check("flush PCSrcE", {31'd0, PCSrcE}, 32'd0);
    check("flush RdE", {27'd0, RdE}, 32'd0);
    @(negedge clk);
    clear_inputs();
    tick();
    check("flush MemWriteM", {31'd0, MemWriteM}, 32'd0);
    check("flush RegWriteM", {31'd0, RegWriteM}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
